// File: rtl/pc_gen_lite.sv
// ============================================================================
// pc_gen_lite: two-slot fetch-address generator with MIPS delay-slot handling
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_gen_lite #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          PTA_W    = 33
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      flush_pc,
  input  logic             mispred,
  input  logic [31:0]      mispred_pc,
  input  logic [PTA_W-1:0] pta0,
  input  logic [PTA_W-1:0] pta1,
  input  logic             fetch_ready,
  output logic [31:0]      pc,
  output logic [31:0]      pc_p4,
  output logic             fetch_req,
  output logic             slot1_valid,
  output logic             pred_taken
);

  localparam int TAKEN_BIT = PTA_W - 1;

  typedef enum logic [0:0] {
    SEQ = 1'b0,
    DS  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] saved_tar;
  logic        adv;
  logic        taken0;
  logic        taken1;

  assign taken0     = pta0[TAKEN_BIT];
  assign taken1     = pta1[TAKEN_BIT];
  assign adv        = fetch_req & fetch_ready & ~stall;
  assign pc_p4      = pc + 32'd4;
  assign pred_taken = (state == SEQ) & (taken0 | taken1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc          <= RESET_PC;
      fetch_req   <= 1'b0;
      slot1_valid <= 1'b1;
      state       <= SEQ;
      saved_tar   <= 32'd0;
    end else begin
      // The front end always has a request outstanding once out of reset.
      fetch_req <= 1'b1;
      if (flush || mispred) begin
        pc          <= flush ? flush_pc : mispred_pc;
        state       <= SEQ;
        slot1_valid <= 1'b1;
        saved_tar   <= 32'd0;
      end else if (adv) begin
        case (state)
          SEQ: begin
            if (taken0) begin
              // Slot1 is the delay slot of slot0's branch, already fetched.
              pc <= pta0[31:0];
            end else if (taken1) begin
              pc          <= pc + 32'd8;
              saved_tar   <= pta1[31:0];
              slot1_valid <= 1'b0;
              state       <= DS;
            end else begin
              pc <= pc + 32'd8;
            end
          end
          DS: begin
            pc          <= saved_tar;
            slot1_valid <= 1'b1;
            state       <= SEQ;
          end
          default: state <= SEQ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_gen_lite.sv
// Testbench for pc_gen_lite: directed spec scenarios plus random traffic,
// scoreboarded against a fetch-stream reference model.
`default_nettype none

module tb_pc_gen_lite;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'd0;
  logic        mispred = 1'b0;
  logic [31:0] mispred_pc = 32'd0;
  logic [32:0] pta0 = 33'd0;
  logic [32:0] pta1 = 33'd0;
  logic        fetch_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_p4;
  logic        fetch_req;
  logic        slot1_valid;
  logic        pred_taken;

  pc_gen_lite #(.RESET_PC(RESET_PC), .PTA_W(33)) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .mispred(mispred), .mispred_pc(mispred_pc), .pta0(pta0), .pta1(pta1),
    .fetch_ready(fetch_ready), .pc(pc), .pc_p4(pc_p4), .fetch_req(fetch_req),
    .slot1_valid(slot1_valid), .pred_taken(pred_taken)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Expected accepted groups: {pc, pc+4, slot1_valid, pred_taken}
  logic [65:0] exp_q[$];

  // Reference model: the next group to be fetched and any pending branch target
  logic [31:0] m_pc;
  logic        m_req;
  logic        m_in_ds;
  logic [31:0] m_tar;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_req = 1'b0; m_in_ds = 1'b0; m_tar = 32'd0;
  endtask

  // Drives one cycle of inputs (called at posedge+1) and advances the model.
  task automatic cycle(input logic f, input logic [31:0] fp, input logic m, input logic [31:0] mp,
                       input logic [32:0] a0, input logic [32:0] a1, input logic rdy, input logic st);
    logic accepted;
    flush = f; flush_pc = fp; mispred = m; mispred_pc = mp;
    pta0 = a0; pta1 = a1; fetch_ready = rdy; stall = st;
    accepted = m_req && rdy && !st;
    if (accepted)
      exp_q.push_back({m_pc, m_pc + 32'd4, !m_in_ds, !m_in_ds && (a0[32] || a1[32])});
    if (f || m) begin
      m_pc = f ? fp : mp;
      m_in_ds = 1'b0;
    end else if (accepted) begin
      if (m_in_ds) begin
        m_pc = m_tar;
        m_in_ds = 1'b0;
      end else if (a0[32]) begin
        m_pc = a0[31:0];
      end else if (a1[32]) begin
        m_tar = a1[31:0];
        m_pc = m_pc + 32'd8;
        m_in_ds = 1'b1;
      end else begin
        m_pc = m_pc + 32'd8;
      end
    end
    m_req = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic go(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic redirect_to(input logic [31:0] a);
    cycle(1, a, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      logic [32:0] a0, a1;
      a0 = {($urandom_range(0, 3) == 0), 30'($urandom), 2'b00};
      a1 = {($urandom_range(0, 3) == 0), 30'($urandom), 2'b00};
      cycle($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 12) == 0, $urandom,
            a0, a1, $urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0);
    end
  endtask

  // Monitor: every handshake the DUT presents must match the next expected group
  always @(negedge clk) begin
    if (resetn && fetch_req && fetch_ready && !stall) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_fetch: got pc %h want no request", pc);
      end else begin
        logic [65:0] e;
        e = exp_q.pop_front();
        if ({pc, pc_p4, slot1_valid, pred_taken} !== e) begin
          bad++;
          $display("FAIL fetch_group: got pc=%h p4=%h s1v=%b pt=%b want pc=%h p4=%h s1v=%b pt=%b",
                   pc, pc_p4, slot1_valid, pred_taken, e[65:34], e[33:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    check("reset_pc", pc, RESET_PC);
    check("reset_pc_p4", pc_p4, RESET_PC + 32'd4);
    check("reset_fetch_req", 32'(fetch_req), 32'd0);
    check("reset_slot1_valid", 32'(slot1_valid), 32'd1);
    check("reset_pred_taken", 32'(pred_taken), 32'd0);

    // Sequential fetch from reset vector
    go(5);
    // pta0 taken: jump, stay sequential
    redirect_to(32'h8000_0100);
    cycle(0, 0, 0, 0, {1'b1, 32'h8000_0400}, 0, 1, 0);
    go(2);
    // pta1 taken: delay slot group, then target, with I-cache backpressure in DS
    redirect_to(32'h8000_0100);
    cycle(0, 0, 0, 0, 0, {1'b1, 32'h8000_0800}, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check("ds_hold_pc", pc, 32'h8000_0108);
    check("ds_hold_slot1", 32'(slot1_valid), 32'd0);
    go(3);
    // Mispredict while in DS abandons the saved target
    redirect_to(32'h8000_0100);
    cycle(0, 0, 0, 0, 0, {1'b1, 32'h8000_0800}, 1, 0);
    cycle(0, 0, 1, 32'h8000_1000, 0, 0, 1, 0);
    check("ds_mispred_pc", pc, 32'h8000_1000);
    go(2);
    // Flush beats mispred and stall
    cycle(1, 32'hBFC0_0380, 1, 32'h1234_5678, 0, 0, 1, 1);
    check("flush_prio_pc", pc, 32'hBFC0_0380);
    go(2);
    // Address wrap
    redirect_to(32'hFFFF_FFF8);
    go(1);
    check("wrap_pc", pc, 32'h0000_0000);
    check("wrap_pc_p4", pc_p4, 32'h0000_0004);
    go(1);

    random_cycles(3000);

    // Asynchronous reset mid-stream
    resetn = 1'b0;
    #1;
    check("async_reset_pc", pc, RESET_PC);
    check("async_reset_req", 32'(fetch_req), 32'd0);
    check("async_reset_slot1", 32'(slot1_valid), 32'd1);
    model_reset();
    pta0 = 0; pta1 = 0; flush = 0; mispred = 0; stall = 0; fetch_ready = 1;
    @(posedge clk); #1;
    resetn = 1'b1;
    random_cycles(2000);

    @(negedge clk); #1;
    check("pending_groups", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
